// File: rtl/rvfi_bus_monitor_if.sv
// Split request/response memory bus as seen by rvfi_bus_monitor.
// The master modport is the side that produces all bus activity, such as a
// core model or a stimulus source. The slave modport is the passive
// observer's view: every signal is an input.
interface rvfi_bus_monitor_if #(
  parameter int XLEN   = 32,
  parameter int BUSLEN = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_data;
  logic [XLEN-1:0]       req_addr;
  logic [BUSLEN/8-1:0]   req_rmask;
  logic [BUSLEN/8-1:0]   req_wmask;
  logic [BUSLEN-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [BUSLEN-1:0]     rsp_rdata;
  logic                  rsp_fault;

  modport master (
    output req_valid, req_ready, req_data, req_addr, req_rmask, req_wmask,
           req_wdata, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_ready, req_data, req_addr, req_rmask, req_wmask,
           req_wdata, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/rvfi_bus_monitor.sv
// rvfi_bus_monitor: passive observer of a split request/response bus.
// Requests are queued in order. Each response pairs with the oldest queued
// request and produces one registered RVFI bus event one cycle later.
// Optional feature macro: RISCV_FORMAL_BUS_TIMEOUT_EN adds a head-request
// watchdog that drives timeout_err. Without the macro, timeout_err is 0.
module rvfi_bus_monitor #(
  parameter int XLEN    = 32,
  parameter int BUSLEN  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  rvfi_bus_monitor_if.slave      bus,
  output logic                   rvfi_bus_valid,
  output logic                   rvfi_bus_insn,
  output logic                   rvfi_bus_data,
  output logic                   rvfi_bus_fault,
  output logic [XLEN-1:0]        rvfi_bus_addr,
  output logic [BUSLEN/8-1:0]    rvfi_bus_rmask,
  output logic [BUSLEN/8-1:0]    rvfi_bus_wmask,
  output logic [BUSLEN-1:0]      rvfi_bus_rdata,
  output logic [BUSLEN-1:0]      rvfi_bus_wdata,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   proto_err,
  output logic                   overflow_err,
  output logic                   timeout_err
);
  localparam int NB = BUSLEN / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rvfi_bus_monitor: DEPTH must be a power of two, at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("rvfi_bus_monitor: TIMEOUT must be at least 1");
  end

  typedef struct packed {
    logic              data;
    logic [XLEN-1:0]   addr;
    logic [NB-1:0]     rmask;
    logic [NB-1:0]     wmask;
    logic [BUSLEN-1:0] wdata;
  } entry_t;

  entry_t        fifo [DEPTH];
  entry_t        head;
  entry_t        incoming;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          accept;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;

  // Zero every byte lane whose mask bit is clear.
  function automatic logic [BUSLEN-1:0] keep_bytes(input logic [BUSLEN-1:0] value,
                                                   input logic [NB-1:0]     mask);
    logic [BUSLEN-1:0] result;
    result = '0;
    for (int i = 0; i < NB; i++) begin
      result[8*i +: 8] = mask[i] ? value[8*i +: 8] : 8'h00;
    end
    return result;
  endfunction

  assign accept = bus.req_valid && bus.req_ready;
  assign empty  = (pending == '0);
  assign full   = (pending == DEPTH_P);
  // A response never pairs with a request accepted in the same cycle.
  assign pop    = bus.rsp_valid && !empty;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign push   = accept && (!full || pop);
  assign head   = fifo[rd_ptr];
  assign incoming = '{data:  bus.req_data,  addr:  bus.req_addr,
                      rmask: bus.req_rmask, wmask: bus.req_wmask,
                      wdata: bus.req_wdata};

  // Request storage; write the accepted request at the tail.
  // NOTE: the storage array has no reset. The pointers and pending alone decide
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= incoming;
  end

  // Queue pointers and occupancy; push and pop only fire when legal, so pending stays in 0..DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      pending <= pending + PW'(push) - PW'(pop);
    end
  end

  // Sticky protocol flags: response with an empty queue, and accept with no free slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      proto_err    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (bus.rsp_valid && empty)  proto_err    <= 1'b1;
      if (accept && full && !pop)  overflow_err <= 1'b1;
    end
  end

  // Registered event: head fields merged with the response; all fields are 0 when no event.
  always_ff @(posedge clock) begin
    if (reset || !pop) begin
      rvfi_bus_valid <= 1'b0;
      rvfi_bus_insn  <= 1'b0;
      rvfi_bus_data  <= 1'b0;
      rvfi_bus_fault <= 1'b0;
      rvfi_bus_addr  <= '0;
      rvfi_bus_rmask <= '0;
      rvfi_bus_wmask <= '0;
      rvfi_bus_rdata <= '0;
      rvfi_bus_wdata <= '0;
    end else begin
      rvfi_bus_valid <= 1'b1;
      rvfi_bus_insn  <= !head.data;
      rvfi_bus_data  <= head.data;
      rvfi_bus_fault <= bus.rsp_fault;
      rvfi_bus_addr  <= head.addr;
      rvfi_bus_rmask <= head.rmask;
      rvfi_bus_wmask <= head.wmask;
      rvfi_bus_rdata <= keep_bytes(bus.rsp_rdata, head.rmask);
      rvfi_bus_wdata <= keep_bytes(head.wdata, head.wmask);
    end
  end

`ifdef RISCV_FORMAL_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  logic [TW-1:0] wait_cnt;

  // Count the cycles the head request has waited; the count saturates at TIMEOUT.
  always_ff @(posedge clock) begin
    if (reset || pop || empty) begin
      wait_cnt <= '0;
    end else if (wait_cnt != TIMEOUT_C) begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  // Sticky watchdog flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (wait_cnt == TIMEOUT_C && !empty) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_bus_monitor.sv
// Self-checking bench for rvfi_bus_monitor. A request queue model turns driven
// responses into expected events. The negedge monitor pops and compares those
// events. Directed tasks check occupancy, the sticky flags and selected event
// contents against literal values.
module tb_rvfi_bus_monitor;
  localparam int XLEN    = 32;
  localparam int BUSLEN  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic        data;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        insn;
    logic        data;
    logic        fault;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rvfi_bus_valid, rvfi_bus_insn, rvfi_bus_data, rvfi_bus_fault;
  logic [31:0] rvfi_bus_addr, rvfi_bus_rdata, rvfi_bus_wdata;
  logic [3:0]  rvfi_bus_rmask, rvfi_bus_wmask;
  logic [2:0]  pending;
  logic        proto_err, overflow_err, timeout_err;

  rvfi_bus_monitor_if #(.XLEN(XLEN), .BUSLEN(BUSLEN)) bus ();

  rvfi_bus_monitor #(.XLEN(XLEN), .BUSLEN(BUSLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .rvfi_bus_valid (rvfi_bus_valid),
    .rvfi_bus_insn  (rvfi_bus_insn),
    .rvfi_bus_data  (rvfi_bus_data),
    .rvfi_bus_fault (rvfi_bus_fault),
    .rvfi_bus_addr  (rvfi_bus_addr),
    .rvfi_bus_rmask (rvfi_bus_rmask),
    .rvfi_bus_wmask (rvfi_bus_wmask),
    .rvfi_bus_rdata (rvfi_bus_rdata),
    .rvfi_bus_wdata (rvfi_bus_wdata),
    .pending        (pending),
    .proto_err      (proto_err),
    .overflow_err   (overflow_err),
    .timeout_err    (timeout_err)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ev_seen  = 0;
  bit   mon_en   = 1'b0;
  req_t req_q[$];
  ev_t  exp_q[$];
  ev_t  last_ev;

  function automatic logic [31:0] mask_bytes(input logic [31:0] v, input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = v[8*i +: 8];
    return r;
  endfunction

  function automatic req_t mk_req(input logic d, input logic [31:0] a, input logic [3:0] rm,
                                  input logic [3:0] wm, input logic [31:0] wd);
    req_t r;
    r.data = d; r.addr = a; r.rmask = rm; r.wmask = wm; r.wdata = wd;
    return r;
  endfunction

  function automatic ev_t mk_ev(input logic i, input logic d, input logic f, input logic [31:0] a,
                                input logic [3:0] rm, input logic [3:0] wm,
                                input logic [31:0] rd, input logic [31:0] wd);
    ev_t e;
    e.insn = i; e.data = d; e.fault = f; e.addr = a;
    e.rmask = rm; e.wmask = wm; e.rdata = rd; e.wdata = wd;
    return e;
  endfunction

  // Scoreboard: compare every cycle's event output against the expected queue.
  always @(negedge clock) begin
    ev_t obs;
    ev_t exp;
    if (mon_en) begin
      obs = mk_ev(rvfi_bus_insn, rvfi_bus_data, rvfi_bus_fault, rvfi_bus_addr,
                  rvfi_bus_rmask, rvfi_bus_wmask, rvfi_bus_rdata, rvfi_bus_wdata);
      n_checks++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        if (rvfi_bus_valid !== 1'b1 || obs !== exp) begin
          n_fail++;
          $display("FAIL event: valid=%b fields=%h expected valid=1 fields=%h",
                   rvfi_bus_valid, obs, exp);
        end
      end else if (rvfi_bus_valid !== 1'b0 || obs !== '0) begin
        n_fail++;
        $display("FAIL idle_event: valid=%b fields=%h expected valid=0 fields=0",
                 rvfi_bus_valid, obs);
      end
      if (rvfi_bus_valid === 1'b1) begin
        ev_seen++;
        last_ev = obs;
      end
    end
  end

  task automatic set_idle();
    bus.req_valid = 1'b0; bus.req_ready = 1'b0; bus.req_data = 1'b0;
    bus.req_addr  = '0;   bus.req_rmask = '0;   bus.req_wmask = '0;
    bus.req_wdata = '0;   bus.rsp_valid = 1'b0; bus.rsp_rdata = '0;
    bus.rsp_fault = 1'b0;
  endtask

  // Drive one cycle and keep the request model in step with the bus.
  task automatic drive(input bit vld, input bit rdy, input req_t r,
                       input bit rsp, input logic [31:0] rd, input bit flt);
    bit   do_pop;
    req_t hd;
    bus.req_valid = vld;     bus.req_ready = rdy;     bus.req_data  = r.data;
    bus.req_addr  = r.addr;  bus.req_rmask = r.rmask; bus.req_wmask = r.wmask;
    bus.req_wdata = r.wdata; bus.rsp_valid = rsp;     bus.rsp_rdata = rd;
    bus.rsp_fault = flt;
    do_pop = rsp && (req_q.size() > 0);
    hd = '0;
    if (do_pop) hd = req_q.pop_front();
    if (vld && rdy && req_q.size() < DEPTH) req_q.push_back(r);
    @(posedge clock);
    if (do_pop)
      exp_q.push_back(mk_ev(!hd.data, hd.data, flt, hd.addr, hd.rmask, hd.wmask,
                            mask_bytes(rd, hd.rmask), mask_bytes(hd.wdata, hd.wmask)));
    #1;
    set_idle();
  endtask

  task automatic accept(input req_t r);
    drive(1'b1, 1'b1, r, 1'b0, '0, 1'b0);
  endtask

  task automatic respond(input logic [31:0] rd, input bit flt);
    drive(1'b0, 1'b0, '0, 1'b1, rd, flt);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    req_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    n_checks++;
    if (pending !== 3'd0) begin
      n_fail++; $display("FAIL reset_pending: got %0d expected 0", pending);
    end
    n_checks++;
    if ({proto_err, overflow_err, timeout_err, rvfi_bus_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got proto=%b ovf=%b tmo=%b valid=%b expected all 0",
               proto_err, overflow_err, timeout_err, rvfi_bus_valid);
    end
  endtask

  task automatic test_single_read();
    int e0 = ev_seen;
    drive(1'b1, 1'b0, mk_req(1'b1, 32'h100, 4'hF, 4'h0, 32'h0), 1'b0, '0, 1'b0);
    n_checks++;
    if (pending !== 3'd0) begin
      n_fail++; $display("FAIL not_ready_pending: got %0d expected 0", pending);
    end
    accept(mk_req(1'b1, 32'h100, 4'hF, 4'h0, 32'h0));
    n_checks++;
    if (pending !== 3'd1) begin
      n_fail++; $display("FAIL read_pending: got %0d expected 1", pending);
    end
    idle();
    respond(32'hDEADBEEF, 1'b0);
    idle();
    n_checks++;
    if (ev_seen !== e0 + 1 ||
        last_ev !== mk_ev(1'b0, 1'b1, 1'b0, 32'h100, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0)) begin
      n_fail++;
      $display("FAIL read_event: got count=%0d ev=%h expected count=%0d addr=100 rdata=deadbeef",
               ev_seen - e0, last_ev, 1);
    end
  endtask

  task automatic test_partial_write_fault();
    accept(mk_req(1'b1, 32'h204, 4'h0, 4'h3, 32'hAABBCCDD));
    respond(32'h12345678, 1'b1);
    idle();
    n_checks++;
    if (last_ev !== mk_ev(1'b0, 1'b1, 1'b1, 32'h204, 4'h0, 4'h3, 32'h0, 32'h0000CCDD)) begin
      n_fail++;
      $display("FAIL write_fault_event: got %h expected wdata=0000ccdd rdata=0 fault=1", last_ev);
    end
  endtask

  task automatic test_ordering();
    int e0 = ev_seen;
    for (int i = 0; i < 4; i++) accept(mk_req(1'b0, 32'(4 * i), 4'hF, 4'h0, 32'h0));
    n_checks++;
    if (pending !== 3'd4) begin
      n_fail++; $display("FAIL order_fill: got %0d expected 4", pending);
    end
    for (int i = 0; i < 4; i++) begin
      respond(32'(17 * (i + 1)), 1'b0);
      n_checks++;
      if (pending !== 3'(3 - i)) begin
        n_fail++; $display("FAIL order_drain_%0d: got %0d expected %0d", i, pending, 3 - i);
      end
    end
    idle();
    n_checks++;
    if (ev_seen !== e0 + 4 ||
        last_ev !== mk_ev(1'b1, 1'b0, 1'b0, 32'hC, 4'hF, 4'h0, 32'h44, 32'h0)) begin
      n_fail++;
      $display("FAIL order_last: got count=%0d ev=%h expected count=4 addr=c rdata=44",
               ev_seen - e0, last_ev);
    end
  endtask

  task automatic test_full_empty();
    int e0 = ev_seen;
    for (int i = 0; i < 4; i++) accept(mk_req(1'b1, 32'h500 + 32'(4 * i), 4'hF, 4'h0, 32'h0));
    accept(mk_req(1'b1, 32'h540, 4'hF, 4'h0, 32'h0));
    n_checks++;
    if (overflow_err !== 1'b1 || pending !== 3'd4) begin
      n_fail++; $display("FAIL overflow: got ovf=%b pending=%0d expected 1 and 4", overflow_err, pending);
    end
    for (int i = 0; i < 4; i++) respond(32'h0, 1'b0);
    idle();
    n_checks++;
    if (ev_seen !== e0 + 4) begin
      n_fail++; $display("FAIL overflow_events: got %0d expected 4", ev_seen - e0);
    end
    respond(32'h0, 1'b0);
    n_checks++;
    if (proto_err !== 1'b1 || pending !== 3'd0) begin
      n_fail++; $display("FAIL proto: got proto=%b pending=%0d expected 1 and 0", proto_err, pending);
    end
    idle();
    n_checks++;
    if (ev_seen !== e0 + 4) begin
      n_fail++; $display("FAIL proto_no_event: got %0d expected 4", ev_seen - e0);
    end
    do_reset();
    n_checks++;
    if ({proto_err, overflow_err} !== 2'b00) begin
      n_fail++; $display("FAIL flags_cleared: got proto=%b ovf=%b expected 0 0", proto_err, overflow_err);
    end
  endtask

  task automatic test_push_pop_full();
    int e0 = ev_seen;
    for (int i = 0; i < 4; i++) accept(mk_req(1'b1, 32'h600 + 32'(4 * i), 4'hF, 4'h0, 32'h0));
    drive(1'b1, 1'b1, mk_req(1'b1, 32'h80, 4'hF, 4'h0, 32'h0), 1'b1, 32'h55, 1'b0);
    n_checks++;
    if (pending !== 3'd4 || overflow_err !== 1'b0) begin
      n_fail++; $display("FAIL push_pop_full: got pending=%0d ovf=%b expected 4 and 0", pending, overflow_err);
    end
    idle();
    n_checks++;
    if (ev_seen !== e0 + 1) begin
      n_fail++; $display("FAIL push_pop_event: got %0d expected 1", ev_seen - e0);
    end
    for (int i = 0; i < 4; i++) respond(32'h77, 1'b0);
    idle();
    n_checks++;
    if (pending !== 3'd0 || last_ev.addr !== 32'h80) begin
      n_fail++; $display("FAIL push_pop_tail: got pending=%0d addr=%h expected 0 and 80", pending, last_ev.addr);
    end
  endtask

  task automatic test_same_cycle_empty();
    int e0;
    do_reset();
    e0 = ev_seen;
    drive(1'b1, 1'b1, mk_req(1'b1, 32'h300, 4'h1, 4'h0, 32'h0), 1'b1, 32'hCAFE0099, 1'b0);
    n_checks++;
    if (proto_err !== 1'b1 || pending !== 3'd1) begin
      n_fail++; $display("FAIL no_bypass: got proto=%b pending=%0d expected 1 and 1", proto_err, pending);
    end
    idle();
    respond(32'h123456AB, 1'b0);
    idle();
    n_checks++;
    if (ev_seen !== e0 + 1 || last_ev.rdata !== 32'hAB || last_ev.addr !== 32'h300) begin
      n_fail++;
      $display("FAIL no_bypass_event: got count=%0d rdata=%h addr=%h expected 1 ab 300",
               ev_seen - e0, last_ev.rdata, last_ev.addr);
    end
  endtask

  task automatic test_zero_masks();
    int e0 = ev_seen;
    accept(mk_req(1'b1, 32'h400, 4'h0, 4'h0, 32'hFFFFFFFF));
    respond(32'hFFFFFFFF, 1'b0);
    idle();
    n_checks++;
    if (ev_seen !== e0 + 1 ||
        last_ev !== mk_ev(1'b0, 1'b1, 1'b0, 32'h400, 4'h0, 4'h0, 32'h0, 32'h0)) begin
      n_fail++; $display("FAIL zero_masks: got count=%0d ev=%h expected 1 with zero data", ev_seen - e0, last_ev);
    end
  endtask

  task automatic test_reset_midflight();
    int e0;
    accept(mk_req(1'b1, 32'h700, 4'hF, 4'h0, 32'h0));
    accept(mk_req(1'b1, 32'h704, 4'hF, 4'h0, 32'h0));
    do_reset();
    e0 = ev_seen;
    n_checks++;
    if (pending !== 3'd0) begin
      n_fail++; $display("FAIL midflight_pending: got %0d expected 0", pending);
    end
    respond(32'h1, 1'b0);
    idle();
    n_checks++;
    if (proto_err !== 1'b1 || ev_seen !== e0) begin
      n_fail++; $display("FAIL midflight_discard: got proto=%b events=%0d expected 1 and 0", proto_err, ev_seen - e0);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    logic exp_tmo;
`ifdef RISCV_FORMAL_BUS_TIMEOUT_EN
    exp_tmo = 1'b1;
`else
    exp_tmo = 1'b0;
`endif
    accept(mk_req(1'b1, 32'h800, 4'hF, 4'h0, 32'h0));
    repeat (8) idle();
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: got %b expected 0", timeout_err);
    end
    idle();
    n_checks++;
    if (timeout_err !== exp_tmo) begin
      n_fail++; $display("FAIL timeout_fire: got %b expected %b", timeout_err, exp_tmo);
    end
    respond(32'h0, 1'b0);
    idle();
    do_reset();
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_reset: got %b expected 0", timeout_err);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_single_read();
    test_partial_write_fault();
    test_ordering();
    test_full_empty();
    test_push_pop_full();
    test_same_cycle_empty();
    test_zero_masks();
    test_reset_midflight();
    test_timeout();
    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rvfi_bus_monitor.md
Name: rvfi_bus_monitor

Overview:
- Passive observer on a core's split request/response memory bus; produces one RVFI bus channel (rvfi_bus_*) per instance.
- Output feeds the bus-level checkers, e.g. data-read and fault consistency checks.
- Tracks up to DEPTH outstanding requests in order.
- Emits one registered event per completed transaction, pairing request fields with response data and fault.

Parameters:
- XLEN, 32, address width; equals RISCV_FORMAL_XLEN.
- BUSLEN, 32, bus data width in bits; byte masks are BUSLEN/8 wide.
- DEPTH, 4, maximum outstanding requests; power of two, at least 2.
- TIMEOUT, 64, maximum cycles a head request may wait for its response; used only with the optional feature.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  in  1  request accepted by the slave. The monitor only observes this signal and never drives it.
- req_data  in  1  1 = data-side access, 0 = instruction fetch.
- req_addr  in  XLEN  byte address of bus lane 0.
- req_rmask  in  BUSLEN/8  read byte mask.
- req_wmask  in  BUSLEN/8  write byte mask.
- req_wdata  in  BUSLEN  write data.
- rsp_valid  in  1  response for the oldest outstanding request.
- rsp_rdata  in  BUSLEN  read data.
- rsp_fault  in  1  bus error for the oldest outstanding request.
- rvfi_bus_valid  out  1  event strobe, one cycle per event.
- rvfi_bus_insn  out  1  event is an instruction fetch.
- rvfi_bus_data  out  1  event is a data access.
- rvfi_bus_fault  out  1  event faulted.
- rvfi_bus_addr  out  XLEN  event address.
- rvfi_bus_rmask  out  BUSLEN/8  event read mask.
- rvfi_bus_wmask  out  BUSLEN/8  event write mask.
- rvfi_bus_rdata  out  BUSLEN  event read data.
- rvfi_bus_wdata  out  BUSLEN  event write data.
- pending  out  clog2(DEPTH)+1  current number of outstanding requests.
- proto_err  out  1  sticky: response arrived with no outstanding request.
- overflow_err  out  1  sticky: a request was accepted while DEPTH requests were already outstanding.
- timeout_err  out  1  sticky: head request waited too long (optional feature).

Behaviour:
- Reset: all outputs 0, FIFO emptied, sticky flags cleared, timeout counter cleared. Reset mid-operation discards all in-flight requests; no event is emitted for them.
- Accept: a request is accepted when req_valid && req_ready. Accepted requests are pushed as {req_data, req_addr, req_rmask, req_wmask, req_wdata}.
- Full: if pending == DEPTH at accept, the request is dropped, overflow_err is set, and the FIFO is unchanged.
- Response handling: on rsp_valid with pending > 0, the head is popped. In the next cycle:
  - rvfi_bus_valid = 1.
  - rvfi_bus_insn = !data; rvfi_bus_data = data.
  - addr, rmask, wmask, wdata come from the head entry.
  - rvfi_bus_fault = rsp_fault.
  - rvfi_bus_rdata = rsp_rdata with every byte whose rmask bit is 0 forced to 0x00.
  - wdata bytes whose wmask bit is 0 are forced to 0x00.
- Latency: exactly 1 cycle from response to event. Every non-valid field is 0 in cycles where rvfi_bus_valid = 0.
- Empty: rsp_valid with pending == 0 sets proto_err, emits no event, and leaves the pointers unchanged. There is no bypass: a response in the same cycle as the first accept counts as empty. That request is still pushed.
- Simultaneous push and pop: when not empty, pending is unchanged and both pointers advance. When full, the pop frees a slot, so the push succeeds and overflow_err is not set.
- Pointers: clog2(DEPTH) bits each and wrap naturally. pending is kept as a separate counter, saturating at 0 and DEPTH.
- Masks of all zero are legal; the event is still emitted.

Optional Feature:
- Macro: RISCV_FORMAL_BUS_TIMEOUT_EN.
- When defined:
  - A counter clears on reset, on every pop, and whenever pending == 0.
  - Otherwise it increments each cycle, saturating.
  - When the counter reaches TIMEOUT while pending > 0, timeout_err is set (sticky).
- When undefined: no counter is built and timeout_err is tied to 0.

Test Plan:
- Single read: accept addr 0x100, rmask 0xF; rsp rdata 0xDEADBEEF two cycles later. Next cycle: valid=1, data=1, addr=0x100, rdata=0xDEADBEEF, fault=0.
- Partial write with fault: accept addr 0x204, wmask 0x3, wdata 0xAABBCCDD; rsp_fault=1. Event shows wdata=0x0000CCDD, rmask=0, rdata=0, fault=1.
- Ordering: four back-to-back accepts (fetches 0x0, 0x4, 0x8, 0xC), then four responses 0x11..0x44. Events appear in address order with matching data and insn=1; pending steps 4→0.
- Full and empty: a fifth accept while pending=4 sets overflow_err with no extra event. A response while pending=0 sets proto_err with no event. Reset clears both flags.
- Push+pop at full: pending=4 with a simultaneous accept and response. pending stays 4, overflow_err stays 0, one event is emitted.
- Timeout (with RISCV_FORMAL_BUS_TIMEOUT_EN, TIMEOUT=8): accept one request and give no response. timeout_err is 1 after cycle 8. Without the macro, timeout_err stays 0.
